qpsk_rx_ber: RTL and testbench

//  Receive-side counterpart of the QPSK tx chain. Takes the tx 8-bit sample stream
//  (oversampling 4) and picks one sample phase per symbol. Slices that sample to a
//  bit, then locks a local PRBS9 reference to the bit stream. Counts checked bits
//  and bit errors for BER measurement; sits after tx in top_level under enable_rx.

---
 rtl/qpsk_rx_ber_if.sv | 21 ++
 rtl/qpsk_rx_ber.sv | 145 ++++++++++++++
 tb/tb_qpsk_rx_ber.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qpsk_rx_ber_if.sv
// rtl/qpsk_rx_ber_if.sv - sample stream in, sliced bit stream out
interface qpsk_rx_ber_if;
    logic       i_valid;
    logic [7:0] i_sample;
    logic       o_bit;
    logic       o_bit_valid;

    modport master (
        output i_valid,
        output i_sample,
        input  o_bit,
        input  o_bit_valid
    );

    modport slave (
        input  i_valid,
        input  i_sample,
        output o_bit,
        output o_bit_valid
    );
endinterface

// File: rtl/qpsk_rx_ber.sv
// rtl/qpsk_rx_ber.sv - QPSK rx sample picker, slicer and PRBS9 BER checker
module qpsk_rx_ber #(
    parameter int WIN_LEN = 128,
    parameter int LOS_THR = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_enable,
    input  logic [1:0]       i_phase,
    input  logic             i_clear,
    qpsk_rx_ber_if.slave     rx_if,
    output logic             o_locked,
    output logic [CNT_W-1:0] o_bit_count,
    output logic [CNT_W-1:0] o_err_count
);
    localparam int WB_W = $clog2(WIN_LEN) + 1;
    localparam logic [WB_W-1:0] WIN_END = WB_W'(WIN_LEN);
    localparam logic [WB_W-1:0] LOS_LIM = WB_W'(LOS_THR);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_CHECK} state_t;

    state_t           state_q;
    logic [1:0]       phase_cnt_q, phase_cnt_d;
    logic             bit_q, bit_d;
    logic             bit_valid_q, bit_valid_d;
    logic [8:0]       lfsr_q;
    logic [3:0]       load_cnt_q;
    logic [WB_W-1:0]  win_bits_q, win_errs_q;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic             decide;
    logic             exp_bit;
    logic             err_bit;
    logic             check_bit;
    logic [8:0]       lfsr_load;
    logic [WB_W-1:0]  win_bits_inc, win_errs_inc;

    always_comb begin
        decide       = rx_if.i_valid && i_enable && (phase_cnt_q == i_phase);
        phase_cnt_d  = (rx_if.i_valid && i_enable) ? phase_cnt_q + 2'd1 : phase_cnt_q;
        bit_d        = decide ? ~rx_if.i_sample[7] : bit_q;
        bit_valid_d  = decide;

        exp_bit      = lfsr_q[8] ^ lfsr_q[4];
        err_bit      = bit_q ^ exp_bit;
        check_bit    = i_enable && bit_valid_q && (state_q == ST_CHECK);
        lfsr_load    = {lfsr_q[7:0], bit_q};
        win_bits_inc = win_bits_q + WB_W'(1);
        win_errs_inc = win_errs_q + {{(WB_W-1){1'b0}}, err_bit};

        // Saturating counters; clear overrides a same-cycle increment.
        bit_cnt_d = bit_cnt_q;
        err_cnt_d = err_cnt_q;
        if (check_bit) begin
            if (~&bit_cnt_q) begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
            if (err_bit && ~&err_cnt_q) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
        end
        if (i_clear) begin
            bit_cnt_d = '0;
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_cnt_q <= '0;
            bit_q       <= 1'b0;
            bit_valid_q <= 1'b0;
            bit_cnt_q   <= '0;
            err_cnt_q   <= '0;
        end else begin
            phase_cnt_q <= phase_cnt_d;
            bit_q       <= bit_d;
            bit_valid_q <= bit_valid_d;
            bit_cnt_q   <= bit_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            lfsr_q     <= '0;
            load_cnt_q <= '0;
            win_bits_q <= '0;
            win_errs_q <= '0;
        end else if (!i_enable) begin
            state_q    <= ST_IDLE;
            win_bits_q <= '0;
            win_errs_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q    <= ST_LOAD;
                    load_cnt_q <= '0;
                    win_bits_q <= '0;
                    win_errs_q <= '0;
                end
                ST_LOAD: begin
                    if (bit_valid_q) begin
                        lfsr_q <= lfsr_load;
                        if (load_cnt_q == 4'd8) begin
                            load_cnt_q <= '0;
                            // An all-zero seed would lock the LFSR at zero forever.
                            if (lfsr_load != '0) begin
                                state_q <= ST_CHECK;
                            end
                        end else begin
                            load_cnt_q <= load_cnt_q + 4'd1;
                        end
                    end
                end
                ST_CHECK: begin
                    if (bit_valid_q) begin
                        lfsr_q <= {lfsr_q[7:0], exp_bit};
                        if (win_bits_inc == WIN_END) begin
                            win_bits_q <= '0;
                            win_errs_q <= '0;
                            if (win_errs_inc >= LOS_LIM) begin
                                state_q    <= ST_LOAD;
                                load_cnt_q <= '0;
                            end
                        end else begin
                            win_bits_q <= win_bits_inc;
                            win_errs_q <= win_errs_inc;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rx_if.o_bit       = bit_q;
    assign rx_if.o_bit_valid = bit_valid_q;
    assign o_locked          = (state_q == ST_CHECK);
    assign o_bit_count       = bit_cnt_q;
    assign o_err_count       = err_cnt_q;
endmodule

// File: tb/tb_qpsk_rx_ber.sv
// tb/tb_qpsk_rx_ber.sv - scoreboard bench for qpsk_rx_ber
module tb_qpsk_rx_ber;
    localparam int WIN = 128;
    localparam int THR = 16;
    localparam int M_IDLE  = 0;
    localparam int M_ACQ   = 1;
    localparam int M_TRACK = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_enable;
    logic        i_clear;
    logic [1:0]  i_phase;
    logic        locked, locked8;
    logic [31:0] bcnt, ecnt;
    logic [7:0]  bcnt8, ecnt8;

    qpsk_rx_ber_if rx ();
    qpsk_rx_ber_if rx8 ();
    assign rx8.i_valid  = rx.i_valid;
    assign rx8.i_sample = rx.i_sample;

    qpsk_rx_ber dut (
        .clk(clk), .rst(rst), .i_enable(i_enable), .i_phase(i_phase),
        .i_clear(i_clear), .rx_if(rx), .o_locked(locked),
        .o_bit_count(bcnt), .o_err_count(ecnt)
    );

    qpsk_rx_ber #(.CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .i_enable(i_enable), .i_phase(i_phase),
        .i_clear(i_clear), .rx_if(rx8), .o_locked(locked8),
        .o_bit_count(bcnt8), .o_err_count(ecnt8)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint got, input longint want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    endtask

    function automatic longint sat8(input longint v);
        return (v > 255) ? 255 : v;
    endfunction

    typedef struct {
        logic b;
        int   cyc;
    } exp_t;
    exp_t exp_q[$];

    // Behavioural reference: received-bit history and a generated reference sequence
    int     m_mode;
    logic   m_acq[$];
    logic   m_ref[$];
    int     m_wbits, m_werrs;
    longint m_bits, m_errs;

    always @(negedge clk) begin
        logic ebv, eb, e, er;
        int   ones;
        if (rst) begin
            m_mode = M_IDLE;
            m_acq.delete();
            m_ref.delete();
            m_wbits = 0; m_werrs = 0;
            m_bits  = 0; m_errs  = 0;
            exp_q.delete();
        end
        check("locked", locked, m_mode == M_TRACK);
        check("locked8", locked8, m_mode == M_TRACK);
        check("bit_count", bcnt, m_bits);
        check("err_count", ecnt, m_errs);
        check("bit_count8", bcnt8, sat8(m_bits));
        check("err_count8", ecnt8, sat8(m_errs));
        ebv = 1'b0;
        eb  = 1'b0;
        if (!rst && exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            ebv = 1'b1;
            eb  = exp_q[0].b;
            void'(exp_q.pop_front());
        end
        check("bit_valid", rx.o_bit_valid, ebv);
        check("bit_valid8", rx8.o_bit_valid, ebv);
        if (ebv) begin
            check("o_bit", rx.o_bit, eb);
            check("o_bit8", rx8.o_bit, eb);
        end
        if (!rst) begin
            if (!i_enable) begin
                m_mode = M_IDLE;
                m_wbits = 0; m_werrs = 0;
            end else if (m_mode == M_IDLE) begin
                m_mode = M_ACQ;
                m_acq.delete();
                m_wbits = 0; m_werrs = 0;
            end else if (ebv && m_mode == M_ACQ) begin
                m_acq.push_back(eb);
                if (m_acq.size() == 9) begin
                    ones = 0;
                    foreach (m_acq[i]) ones += int'(m_acq[i]);
                    if (ones != 0) begin
                        m_ref  = m_acq;
                        m_mode = M_TRACK;
                    end
                    m_acq.delete();
                end
            end else if (ebv && m_mode == M_TRACK) begin
                e  = m_ref[0] ^ m_ref[4];
                m_ref.push_back(e);
                void'(m_ref.pop_front());
                er = eb ^ e;
                m_bits++;
                m_errs  += longint'(er);
                m_wbits++;
                m_werrs += int'(er);
                if (m_wbits == WIN) begin
                    if (m_werrs >= THR) begin
                        m_mode = M_ACQ;
                        m_acq.delete();
                    end
                    m_wbits = 0; m_werrs = 0;
                end
            end
            if (i_clear) begin
                m_bits = 0;
                m_errs = 0;
            end
        end
    end

    int   tb_ph;
    logic gen_h[$];

    task automatic drive(input logic v, input logic [7:0] s, input logic clr);
        rx.i_valid  = v;
        rx.i_sample = s;
        i_clear     = clr;
        if (v && i_enable) begin
            if (tb_ph == int'(i_phase))
                exp_q.push_back('{b: ($signed(s) >= 8'sd0), cyc: cyc + 1});
            tb_ph = (tb_ph + 1) % 4;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic prbs_next(output logic b);
        b = gen_h[0] ^ gen_h[4];
        gen_h.push_back(b);
        void'(gen_h.pop_front());
    endtask

    task automatic send_sym(input logic b, input int clr_pos, input bit gaps);
        logic [7:0] s;
        for (int k = 0; k < 4; k++) begin
            if (gaps && $urandom_range(0, 9) == 0) drive(1'b0, 8'($urandom), 1'b0);
            if (tb_ph == int'(i_phase)) s = b ? {1'b0, 7'($urandom)} : {1'b1, 7'($urandom)};
            else s = 8'($urandom);
            drive(1'b1, s, k == clr_pos);
        end
    endtask

    task automatic send_prbs(input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            prbs_next(b);
            send_sym(b, -1, 1'b1);
        end
    endtask

    task automatic relock_start();
        i_enable = 1'b0;
        drive(1'b1, 8'($urandom), 1'b0);
        drive(1'b1, 8'($urandom), 1'b0);
        i_enable = 1'b1;
        idle(2);
    endtask

    initial begin
        logic   b;
        longint snap_bits, snap_errs;
        int     clr_pos;
        rst = 1'b1; i_enable = 1'b0; i_clear = 1'b0; i_phase = 2'd0;
        rx.i_valid = 1'b0; rx.i_sample = 8'h00; tb_ph = 0;
        for (int i = 0; i < 9; i++) gen_h.push_back(1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("reset_locked", locked, 0);
        check("reset_bit_count", bcnt, 0);
        check("reset_err_count", ecnt, 0);
        check("reset_bit_valid", rx.o_bit_valid, 0);
        check("reset_bit", rx.o_bit, 0);
        rst = 1'b0;
        idle(1);
        i_enable = 1'b1;
        idle(2);

        send_prbs(200);
        idle(6);
        check("clean_bits", bcnt, 191);
        check("clean_errs", ecnt, 0);
        check("clean_locked", locked, 1);
        check("clean_bits8", bcnt8, 191);

        send_prbs(30);
        prbs_next(b);
        send_sym(~b, -1, 1'b1);
        send_prbs(30);
        idle(6);
        check("single_err", ecnt, 1);
        check("single_bits", bcnt, 252);
        check("single_locked", locked, 1);
        send_prbs(60);
        idle(6);
        check("bits_wide", bcnt, 312);
        check("sat_bits8", bcnt8, 255);

        for (int i = 0; i < 128; i++) send_sym(1'b1, -1, 1'b1);
        send_prbs(300);
        idle(6);
        check("relock_locked", locked, 1);

        relock_start();
        snap_bits = m_bits;
        snap_errs = m_errs;
        for (int i = 0; i < 20; i++) send_sym(1'b0, -1, 1'b1);
        idle(6);
        check("guard_unlocked", locked, 0);
        check("guard_bits", bcnt, snap_bits);
        check("guard_errs", ecnt, snap_errs);
        relock_start();
        send_prbs(20);
        check("guard_relock", locked, 1);

        i_phase = 2'd2;
        drive(1'b1, 8'hC0, 1'b0);
        drive(1'b1, 8'hC0, 1'b0);
        drive(1'b1, 8'h40, 1'b0);
        check("phase2_strobe", rx.o_bit_valid, 1);
        check("phase2_bit", rx.o_bit, 1);
        drive(1'b1, 8'hC0, 1'b0);
        check("phase2_one_clk", rx.o_bit_valid, 0);
        i_phase = 2'd1;
        drive(1'b1, 8'h40, 1'b0);
        drive(1'b1, 8'hC0, 1'b0);
        check("phase1_strobe", rx.o_bit_valid, 1);
        check("phase1_bit", rx.o_bit, 0);
        drive(1'b1, 8'h40, 1'b0);
        drive(1'b1, 8'h40, 1'b0);
        i_phase = 2'd0;

        relock_start();
        send_prbs(20);
        check("clear_pre_locked", locked, 1);
        prbs_next(b);
        send_sym(b, 1, 1'b0);
        check("clear_bits", bcnt, 0);
        check("clear_errs", ecnt, 0);
        check("clear_bits8", bcnt8, 0);
        check("clear_keeps_lock", locked, 1);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) i_phase = 2'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                i_enable = 1'b0;
                drive(1'b1, 8'($urandom), 1'b0);
                i_enable = 1'b1;
            end
            prbs_next(b);
            if ($urandom_range(0, 19) == 0) b = ~b;
            clr_pos = ($urandom_range(0, 49) == 0) ? int'($urandom_range(0, 3)) : -1;
            send_sym(b, clr_pos, 1'b1);
        end

        i_phase = 2'd0;
        relock_start();
        send_prbs(20);
        check("rst_pre_locked", locked, 1);
        #2;
        rst = 1'b1;
        rx.i_valid = 1'b0;
        tb_ph = 0;
        #1;
        check("rst_async_locked", locked, 0);
        check("rst_async_bits", bcnt, 0);
        check("rst_async_errs", ecnt, 0);
        check("rst_async_valid", rx.o_bit_valid, 0);
        check("rst_async_bit", rx.o_bit, 0);
        check("rst_async_bits8", bcnt8, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);
        send_prbs(40);
        idle(6);
        check("post_rst_locked", locked, 1);
        check("post_rst_errs", ecnt, 0);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
